dram_sequencer: RTL and testbench
=================================

Name: dram_sequencer

Overview:
- Sequences the VG8020 main-memory DRAM from raw Z80 bus strobes.
- Generates nRAS, nCAS, the row/column address-mux select, nWE and Z80 nWAIT.
- Serves CPU read/write cycles and Z80 RAS-only refresh cycles.
- Inserts a CAS-before-RAS refresh when no refresh has occurred within REFRESH_MAX clocks.
- Sits between the Z80 bus buffers and the DRAM array, replacing the combinational write-enable decode.

Parameters:
- T_RAS_TO_MUX, 1: clocks with nras=0, mux=0 before switching to column address.
- T_MUX_TO_CAS, 1: minimum clocks with mux=1 before ncas falls.
- T_PRECHARGE, 2: clocks nras and ncas held high after any access.
- T_CBR_RAS, 2: clocks nras held low during forced CBR refresh.
- REFRESH_MAX, 512: clocks without refresh before a CBR refresh becomes pending.

Ports:
- clk  in  1  system clock (≥4× Z80 clock)
- nreset  in  1  asynchronous active-low reset
- nmreq  in  1  Z80 /MREQ, asynchronous to clk
- nrd  in  1  Z80 /RD, asynchronous
- nwr  in  1  Z80 /WR, asynchronous
- nrfsh  in  1  Z80 /RFSH, asynchronous
- nras  out  1  DRAM row strobe, active low
- ncas  out  1  DRAM column strobe, active low
- mux  out  1  address mux select: 0 = row, 1 = column
- nwe  out  1  DRAM write enable, active low
- nwait  out  1  Z80 /WAIT, active low

Behaviour:
- Clock and reset: one clock, clk. Reset nreset is asynchronous, active-low.
- Reset (asserted at any time, including mid-access): state IDLE; nras=ncas=nwe=nwait=1; mux=0; refresh counter=0; pending=0; synchronizers=1.
- Input synchronization:
  - All four strobes pass through a 2-flop synchronizer.
  - FSM sees an input change on the 2nd rising edge after it.
  - All outputs are registered, taken directly from state/flags.
- States: IDLE, ROW, COL, CAS, RFSH, CBR_CAS, CBR_RAS, PRECH.
- IDLE:
  - Synced nmreq=0 and nrfsh=0 → RFSH. nrd/nwr are ignored.
  - Synced nmreq=0 and nrfsh=1 → ROW.
  - Otherwise, pending=1 → CBR_CAS.
  - A CPU request and pending in the same cycle: CPU wins, pending is held.
- ROW: nras=0, mux=0 for T_RAS_TO_MUX clocks → COL.
- COL:
  - nras=0, mux=1.
  - After T_MUX_TO_CAS clocks, leave on synced nrd=0 or nwr=0 → CAS. Otherwise stay (Z80 /WR lags /MREQ).
  - Synced nmreq=1 while still in COL → PRECH.
- CAS:
  - ncas=0, nras=0, mux=1.
  - nwe=0 for the whole CAS phase if the cycle entered CAS with nwr=0 (early write). Otherwise nwe=1.
  - Stay until synced nmreq=1 → PRECH.
- RFSH: nras=0, mux=0, ncas=1. Stay until synced nmreq=1 → PRECH. Clears counter and pending on entry.
- CBR_CAS: ncas=0, nras=1 for 1 clock → CBR_RAS.
- CBR_RAS: ncas=0, nras=0 for T_CBR_RAS clocks → PRECH. Clears counter and pending on entry.
- PRECH:
  - All strobes high, mux=0, nwe=1 for exactly T_PRECHARGE clocks → IDLE.
  - A new nmreq during PRECH is held off until IDLE.
- Refresh counter:
  - Increments every clock outside RFSH/CBR_RAS.
  - Sets pending when it reaches REFRESH_MAX−1.
  - Saturates there; never wraps.
  - Width = clog2(REFRESH_MAX).
- nwait:
  - Goes 0 the clock after synced nmreq=0 is seen while the state is CBR_CAS, CBR_RAS, or a PRECH that follows a CBR.
  - Returns to 1 on entry to ROW.
  - nwait=1 in every other state.
- Strobe ordering guarantees:
  - ncas never falls while nras=1, except in CBR_CAS.
  - mux changes only while ncas=1.

Decomposition:
- Shared package/header: state encoding constants, default timing values, counter-width helper.
- Sub-module `bus_sync`: 4-bit two-flop synchronizer, reset to all-ones.
- FSM, counters and refresh watchdog live in `dram_sequencer`.

Test Plan:
- Read:
  - Stimulus: nmreq=nrd=0 before edge 1, nwr=1.
  - Response: nras=0 after edge 3; mux=1 after edge 4; ncas=0 after edge 5; nwe stays 1.
  - Release nmreq before edge k → nras=ncas=1 after edge k+2, held high ≥2 clocks.
- Write with late /WR:
  - Stimulus: nmreq=0 at edge 1; nwr=0 at edge 4.
  - Response: stays in COL (ncas=1) until after edge 6; ncas=0 and nwe=0 together after edge 7; nwe=1 when PRECH is entered.
- Z80 refresh:
  - Stimulus: nmreq=nrfsh=0 for 6 clocks.
  - Response: nras=0 from edge 3, ncas=1 throughout, mux=0; counter reads 0 after the cycle.
- Forced CBR:
  - Stimulus: REFRESH_MAX=16, bus idle.
  - Response: pending set at count 15; ncas=0 one clock before nras=0; nras low 2 clocks; then 2 clocks precharge; counter reset.
- Collision:
  - Stimulus: nmreq=nrd=0 arrives while in CBR_RAS.
  - Response: nwait=0 next clock; read starts (nras=0) only after the 2 PRECH clocks; nwait=1 on ROW entry.
- Reset mid-write:
  - Stimulus: nreset=0 while ncas=nwe=0.
  - Response: nras=ncas=nwe=nwait=1, mux=0 immediately (asynchronous); after release, IDLE with no spurious strobes.

Source files
------------

// File: rtl/dram_sequencer_pkg.sv
// Shared definitions for the VG8020 DRAM sequencer: state encoding,
// default timing values, strobe bit positions and the counter-width helper.
package dram_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ROW     = 3'd1,
    ST_COL     = 3'd2,
    ST_CAS     = 3'd3,
    ST_RFSH    = 3'd4,
    ST_CBR_CAS = 3'd5,
    ST_CBR_RAS = 3'd6,
    ST_PRECH   = 3'd7
  } state_t;

  localparam int T_RAS_TO_MUX_DEF = 1;
  localparam int T_MUX_TO_CAS_DEF = 1;
  localparam int T_PRECHARGE_DEF  = 2;
  localparam int T_CBR_RAS_DEF    = 2;
  localparam int REFRESH_MAX_DEF  = 512;

  // Bit positions of the Z80 strobes inside the synchronizer vector.
  localparam int NUM_STROBES = 4;
  localparam int STB_MREQ    = 0;
  localparam int STB_RD      = 1;
  localparam int STB_WR      = 2;
  localparam int STB_RFSH    = 3;

  // Width of the per-state timing counter; comfortably covers any sane timing value.
  localparam int TMR_W = 8;

  // Refresh counter width: clog2 of the limit, never below one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dram_sequencer_bus_sync.sv
// Two-flop synchronizer for the asynchronous Z80 bus strobes.
// Resets to all-ones so every strobe reads as inactive out of reset.
module bus_sync
  import dram_sequencer_pkg::*;
#(
  parameter int WIDTH = NUM_STROBES
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  // Two-stage capture; the second stage is the metastability-settled copy.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  assign dout = sync_p1;

endmodule

// File: rtl/dram_sequencer.sv
// DRAM sequencer for the VG8020 main memory. Turns raw Z80 strobes into
// nRAS/nCAS/mux/nWE, serves CPU and Z80 RAS-only refresh cycles, and forces a
// CAS-before-RAS refresh when the Z80 has not refreshed for REFRESH_MAX clocks.
module dram_sequencer
  import dram_sequencer_pkg::*;
#(
  parameter int T_RAS_TO_MUX = T_RAS_TO_MUX_DEF,
  parameter int T_MUX_TO_CAS = T_MUX_TO_CAS_DEF,
  parameter int T_PRECHARGE  = T_PRECHARGE_DEF,
  parameter int T_CBR_RAS    = T_CBR_RAS_DEF,
  parameter int REFRESH_MAX  = REFRESH_MAX_DEF
) (
  input  logic clk,
  input  logic nreset,
  input  logic nmreq,
  input  logic nrd,
  input  logic nwr,
  input  logic nrfsh,
  output logic nras,
  output logic ncas,
  output logic mux,
  output logic nwe,
  output logic nwait
);

  localparam int               CNT_W    = cnt_width(REFRESH_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_MAX - 1);
  localparam logic [TMR_W-1:0] ROW_LAST = TMR_W'(T_RAS_TO_MUX - 1);
  localparam logic [TMR_W-1:0] COL_LAST = TMR_W'(T_MUX_TO_CAS - 1);
  localparam logic [TMR_W-1:0] CBR_LAST = TMR_W'(T_CBR_RAS - 1);
  localparam logic [TMR_W-1:0] PRE_LAST = TMR_W'(T_PRECHARGE - 1);

  logic [NUM_STROBES-1:0] strobes;
  logic [NUM_STROBES-1:0] strobes_s;
  logic                   mreq, rd, wr, rfsh;

  state_t           state, state_nx;
  logic [TMR_W-1:0] tmr;
  logic             wr_cycle, wr_cycle_nx;
  logic             after_cbr, after_cbr_nx;
  logic             cbr_window;
  logic [CNT_W-1:0] rcnt;
  logic             pending;
  logic             nras_nx, ncas_nx, mux_nx, nwe_nx, nwait_nx;

  assign strobes = {nrfsh, nwr, nrd, nmreq};

  bus_sync #(.WIDTH(NUM_STROBES)) u_sync (
    .clk    (clk),
    .nreset (nreset),
    .din    (strobes),
    .dout   (strobes_s)
  );

  // Active-high views of the synchronized strobes.
  assign mreq = ~strobes_s[STB_MREQ];
  assign rd   = ~strobes_s[STB_RD];
  assign wr   = ~strobes_s[STB_WR];
  assign rfsh = ~strobes_s[STB_RFSH];

  // Next state, cycle flags and next output values; outputs are then registered.
  always_comb begin
    state_nx     = state;
    wr_cycle_nx  = wr_cycle;
    after_cbr_nx = after_cbr;
    case (state)
      ST_IDLE: begin
        // A CPU request beats a pending CBR; pending stays set for later.
        if (mreq && rfsh)  state_nx = ST_RFSH;
        else if (mreq)     state_nx = ST_ROW;
        else if (pending)  state_nx = ST_CBR_CAS;
      end
      ST_ROW:     if (tmr >= ROW_LAST) state_nx = ST_COL;
      ST_COL: begin
        // /WR trails /MREQ on Z80 writes, so wait here for rd or wr.
        if (!mreq)                              state_nx = ST_PRECH;
        else if ((tmr >= COL_LAST) && (rd || wr)) state_nx = ST_CAS;
      end
      ST_CAS:     if (!mreq) state_nx = ST_PRECH;
      ST_RFSH:    if (!mreq) state_nx = ST_PRECH;
      ST_CBR_CAS: state_nx = ST_CBR_RAS;
      ST_CBR_RAS: if (tmr >= CBR_LAST) state_nx = ST_PRECH;
      ST_PRECH:   if (tmr >= PRE_LAST) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase

    // Write enable is decided once, at CAS entry, and held for the whole CAS phase.
    if ((state_nx == ST_CAS) && (state != ST_CAS)) wr_cycle_nx = wr;
    if ((state_nx == ST_PRECH) && (state != ST_PRECH)) after_cbr_nx = (state == ST_CBR_RAS);

    // The CPU must be stalled if it arrives while a forced refresh owns the array.
    cbr_window = (state == ST_CBR_CAS) || (state == ST_CBR_RAS) ||
                 ((state == ST_PRECH) && after_cbr);

    nras_nx  = !(state_nx inside {ST_ROW, ST_COL, ST_CAS, ST_RFSH, ST_CBR_RAS});
    ncas_nx  = !(state_nx inside {ST_CAS, ST_CBR_CAS, ST_CBR_RAS});
    mux_nx   = state_nx inside {ST_COL, ST_CAS};
    nwe_nx   = !((state_nx == ST_CAS) && wr_cycle_nx);
    nwait_nx = !(mreq && (cbr_window || !nwait) &&
                 (state_nx inside {ST_CBR_CAS, ST_CBR_RAS, ST_PRECH, ST_IDLE}));
  end

  // State register, cycle flags and registered DRAM/Z80 outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= ST_IDLE;
      wr_cycle  <= 1'b0;
      after_cbr <= 1'b0;
      nras      <= 1'b1;
      ncas      <= 1'b1;
      mux       <= 1'b0;
      nwe       <= 1'b1;
      nwait     <= 1'b1;
    end else begin
      state     <= state_nx;
      wr_cycle  <= wr_cycle_nx;
      after_cbr <= after_cbr_nx;
      nras      <= nras_nx;
      ncas      <= ncas_nx;
      mux       <= mux_nx;
      nwe       <= nwe_nx;
      nwait     <= nwait_nx;
    end
  end

  // Clocks spent in the current state; restarts on every state change.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tmr <= '0;
    end else if (state_nx != state) begin
      tmr <= '0;
    end else if (tmr != '1) begin
      tmr <= tmr + 1'b1;
    end
  end

  // Refresh watchdog: any refresh clears it, otherwise it counts up and saturates.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rcnt    <= '0;
      pending <= 1'b0;
    end else if ((state_nx == ST_RFSH) || (state_nx == ST_CBR_RAS)) begin
      rcnt    <= '0;
      pending <= 1'b0;
    end else if (rcnt != CNT_LAST) begin
      rcnt    <= rcnt + 1'b1;
      pending <= (rcnt == (CNT_LAST - 1'b1));
    end
  end

endmodule

// File: tb/tb_dram_sequencer.sv
// Bench for dram_sequencer: directed timing checks with literal expectations,
// then randomized Z80 bus traffic compared every cycle against a phase model.
module tb_dram_sequencer;

  localparam int T_RM = 1;
  localparam int T_MC = 1;
  localparam int T_PRE = 2;
  localparam int T_CBR = 2;
  localparam int RMAX = 16;

  localparam int P_IDLE = 0, P_ROW = 1, P_COL = 2, P_CAS = 3,
                 P_RFSH = 4, P_CBRC = 5, P_CBRR = 6, P_PRE = 7;

  logic clk = 1'b0;
  logic nreset;
  logic nmreq = 1'b1, nrd = 1'b1, nwr = 1'b1, nrfsh = 1'b1;
  logic nras, ncas, mux, nwe, nwait;

  int n_cmp = 0;
  int n_bad = 0;
  int e = 0;

  dram_sequencer #(
    .T_RAS_TO_MUX (T_RM),
    .T_MUX_TO_CAS (T_MC),
    .T_PRECHARGE  (T_PRE),
    .T_CBR_RAS    (T_CBR),
    .REFRESH_MAX  (RMAX)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .nmreq  (nmreq),
    .nrd    (nrd),
    .nwr    (nwr),
    .nrfsh  (nrfsh),
    .nras   (nras),
    .ncas   (ncas),
    .mux    (mux),
    .nwe    (nwe),
    .nwait  (nwait)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    int ph;     // current bus phase
    int age;    // clocks already spent in the phase
    int since;  // clocks since the last refresh of any kind
    bit mwr;    // current CAS phase is a write
    bit aftc;   // current precharge follows a forced refresh
    bit wlo;    // Z80 is being held in wait
  } mstate_t;

  mstate_t    m;
  logic [3:0] seen1, seen2;
  logic       e_nras, e_ncas, e_mux, e_nwe, e_nwait;

  function automatic int phase_len(input int ph);
    case (ph)
      P_ROW:   return T_RM;
      P_COL:   return T_MC;
      P_CBRR:  return T_CBR;
      P_PRE:   return T_PRE;
      default: return 1;
    endcase
  endfunction

  function automatic mstate_t step(input mstate_t c, input logic [3:0] s);
    mstate_t n;
    bit mreq, rd, wr, rf, done, win;
    n    = c;
    mreq = !s[0];
    rd   = !s[1];
    wr   = !s[2];
    rf   = !s[3];
    done = (c.age + 1 >= phase_len(c.ph));
    case (c.ph)
      P_IDLE: begin
        if (mreq) n.ph = rf ? P_RFSH : P_ROW;
        else if (c.since == RMAX - 1) n.ph = P_CBRC;
      end
      P_ROW: if (done) n.ph = P_COL;
      P_COL: begin
        if (!mreq) begin n.ph = P_PRE; n.aftc = 0; end
        else if (done && (rd || wr)) begin n.ph = P_CAS; n.mwr = wr; end
      end
      P_CAS, P_RFSH: if (!mreq) begin n.ph = P_PRE; n.aftc = 0; end
      P_CBRC: n.ph = P_CBRR;
      P_CBRR: if (done) begin n.ph = P_PRE; n.aftc = 1; end
      P_PRE:  if (done) n.ph = P_IDLE;
      default: n.ph = P_IDLE;
    endcase
    n.age = (n.ph == c.ph) ? c.age + 1 : 0;
    if (n.ph == P_RFSH || n.ph == P_CBRR) n.since = 0;
    else if (c.since < RMAX - 1)          n.since = c.since + 1;
    win   = (c.ph == P_CBRC) || (c.ph == P_CBRR) || (c.ph == P_PRE && c.aftc);
    n.wlo = mreq && (win || c.wlo) &&
            (n.ph == P_CBRC || n.ph == P_CBRR || n.ph == P_PRE || n.ph == P_IDLE);
    return n;
  endfunction

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m     <= '0;
      seen1 <= 4'hF;
      seen2 <= 4'hF;
    end else begin
      m     <= step(m, seen2);
      seen1 <= {nrfsh, nwr, nrd, nmreq};
      seen2 <= seen1;
    end
  end

  always_comb begin
    e_nras  = !(m.ph == P_ROW || m.ph == P_COL || m.ph == P_CAS ||
                m.ph == P_RFSH || m.ph == P_CBRR);
    e_ncas  = !(m.ph == P_CAS || m.ph == P_CBRC || m.ph == P_CBRR);
    e_mux   = (m.ph == P_COL || m.ph == P_CAS);
    e_nwe   = !(m.ph == P_CAS && m.mwr);
    e_nwait = !m.wlo;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_nras", nras, e_nras);
    check("model_ncas", ncas, e_ncas);
    check("model_mux", mux, e_mux);
    check("model_nwe", nwe, e_nwe);
    check("model_nwait", nwait, e_nwait);
  end

  // ---------------- stimulus helpers ----------------
  task automatic start();
    nreset = 1'b0;
    nmreq = 1'b1; nrd = 1'b1; nwr = 1'b1; nrfsh = 1'b1;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    e = 0;
  endtask

  task automatic at_edge(input int k);
    while (e < k) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask

  task automatic bus_cycle(input int kind, input int len, input int wdly);
    @(negedge clk);
    nmreq = 1'b0;
    if (kind == 0) nrd = 1'b0;
    if (kind == 2) nrfsh = 1'b0;
    for (int j = 0; j < len; j++) begin
      if (kind == 1 && j == wdly) nwr = 1'b0;
      @(negedge clk);
    end
    nmreq = 1'b1; nrd = 1'b1; nwr = 1'b1; nrfsh = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    nreset = 1'b0;

    // Reset values
    start();
    check("rst_nras", nras, 1'b1);
    check("rst_ncas", ncas, 1'b1);
    check("rst_mux", mux, 1'b0);
    check("rst_nwe", nwe, 1'b1);
    check("rst_nwait", nwait, 1'b1);

    // Read
    start();
    nmreq = 1'b0; nrd = 1'b0;
    at_edge(2);  check("rd_nras_e2", nras, 1'b1);
    at_edge(3);  check("rd_nras_e3", nras, 1'b0); check("rd_mux_e3", mux, 1'b0);
    at_edge(4);  check("rd_mux_e4", mux, 1'b1);   check("rd_ncas_e4", ncas, 1'b1);
    at_edge(5);  check("rd_ncas_e5", ncas, 1'b0); check("rd_nwe_e5", nwe, 1'b1);
    at_edge(6);  @(negedge clk); nmreq = 1'b1; nrd = 1'b1;
    at_edge(8);  check("rd_ncas_e8", ncas, 1'b0);
    at_edge(9);  check("rd_nras_e9", nras, 1'b1); check("rd_ncas_e9", ncas, 1'b1);
    check("rd_mux_e9", mux, 1'b0);
    at_edge(10); check("rd_nras_e10", nras, 1'b1); check("rd_ncas_e10", ncas, 1'b1);

    // Write with late /WR
    start();
    nmreq = 1'b0;
    at_edge(4);  @(negedge clk); nwr = 1'b0;
    at_edge(5);  check("wr_ncas_e5", ncas, 1'b1); check("wr_mux_e5", mux, 1'b1);
    at_edge(6);  check("wr_ncas_e6", ncas, 1'b1); check("wr_nwe_e6", nwe, 1'b1);
    at_edge(7);  check("wr_ncas_e7", ncas, 1'b0); check("wr_nwe_e7", nwe, 1'b0);
    at_edge(8);  @(negedge clk); nmreq = 1'b1; nwr = 1'b1;
    at_edge(10); check("wr_nwe_e10", nwe, 1'b0);
    at_edge(11); check("wr_nwe_e11", nwe, 1'b1); check("wr_ncas_e11", ncas, 1'b1);

    // Z80 refresh, then the watchdog restarts from zero
    start();
    nmreq = 1'b0; nrfsh = 1'b0;
    for (int k = 3; k <= 8; k++) begin
      at_edge(k);
      check("rf_nras", nras, 1'b0);
      check("rf_ncas", ncas, 1'b1);
      check("rf_mux", mux, 1'b0);
      if (k == 6) begin @(negedge clk); nmreq = 1'b1; nrfsh = 1'b1; end
    end
    at_edge(9);  check("rf_nras_e9", nras, 1'b1);
    at_edge(23); check("rf_cbr_ncas_e23", ncas, 1'b1);
    at_edge(24); check("rf_cbr_ncas_e24", ncas, 1'b0); check("rf_cbr_nras_e24", nras, 1'b1);

    // Forced CBR on an idle bus
    start();
    at_edge(15); check("cbr_ncas_e15", ncas, 1'b1);
    at_edge(16); check("cbr_ncas_e16", ncas, 1'b0); check("cbr_nras_e16", nras, 1'b1);
    check("cbr_model_ncas_e16", e_ncas, 1'b0);
    at_edge(17); check("cbr_nras_e17", nras, 1'b0); check("cbr_ncas_e17", ncas, 1'b0);
    at_edge(18); check("cbr_nras_e18", nras, 1'b0);
    at_edge(19); check("cbr_nras_e19", nras, 1'b1); check("cbr_ncas_e19", ncas, 1'b1);
    at_edge(20); check("cbr_nras_e20", nras, 1'b1);
    at_edge(33); check("cbr2_ncas_e33", ncas, 1'b1);
    at_edge(34); check("cbr2_ncas_e34", ncas, 1'b0); check("cbr2_model_ncas", e_ncas, 1'b0);

    // CPU read colliding with CBR_RAS
    start();
    at_edge(17); @(negedge clk); nmreq = 1'b0; nrd = 1'b0;
    at_edge(19); check("col_nwait_e19", nwait, 1'b1); check("col_nras_e19", nras, 1'b1);
    at_edge(20); check("col_nwait_e20", nwait, 1'b0); check("col_model_nwait", e_nwait, 1'b0);
    at_edge(21); check("col_nwait_e21", nwait, 1'b0); check("col_nras_e21", nras, 1'b1);
    at_edge(22); check("col_nwait_e22", nwait, 1'b1); check("col_nras_e22", nras, 1'b0);
    at_edge(23); check("col_mux_e23", mux, 1'b1);
    @(negedge clk); nmreq = 1'b1; nrd = 1'b1;
    repeat (6) @(negedge clk);

    // Reset in the middle of a write
    start();
    nmreq = 1'b0;
    at_edge(3); @(negedge clk); nwr = 1'b0;
    at_edge(7); check("mrst_ncas_pre", ncas, 1'b0); check("mrst_nwe_pre", nwe, 1'b0);
    #2 nreset = 1'b0;
    #1;
    check("mrst_nras", nras, 1'b1);
    check("mrst_ncas", ncas, 1'b1);
    check("mrst_nwe", nwe, 1'b1);
    check("mrst_nwait", nwait, 1'b1);
    check("mrst_mux", mux, 1'b0);
    nmreq = 1'b1; nwr = 1'b1;
    @(negedge clk);
    nreset = 1'b1;
    e = 0;
    for (int k = 1; k <= 5; k++) begin
      at_edge(k);
      check("mrst_post_nras", nras, 1'b1);
      check("mrst_post_ncas", ncas, 1'b1);
    end

    // Randomized bus traffic against the model
    start();
    for (int i = 0; i < 500; i++) begin
      int kind;
      int gap;
      kind = $urandom_range(0, 9);
      if (kind <= 6) begin
        bus_cycle(kind % 3, $urandom_range(1, 10), $urandom_range(0, 3));
      end else if (kind == 9 && $urandom_range(0, 7) == 0) begin
        @(negedge clk);
        #2 nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
      end
      gap = $urandom_range(0, 24);
      repeat (gap) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
